// File: rtl/ecc_scrubber_pkg.sv
// Shared types and SECDED constants for the ECC scrubber and its (39,32) Hsiao codec.
package ecc_scrubber_pkg;

  localparam int unsigned SecdedDataW = 32;
  localparam int unsigned SecdedCodeW = 39;
  localparam int unsigned SecdedParW  = SecdedCodeW - SecdedDataW;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    CORRECT
  } scrub_state_e;

  typedef logic [SecdedDataW-1:0][SecdedParW-1:0] secded_cols_t;

  // Data bit i owns the i-th weight-3 parity column in ascending order; check bits use weight 1.
  function automatic secded_cols_t secded_cols();
    secded_cols_t cols;
    int n;
    int w;
    cols = '0;
    n = 0;
    for (int v = 0; v < 128; v++) begin
      w = 0;
      for (int b = 0; b < 7; b++) w += (v >> b) & 1;
      if (w == 3 && n < 32) begin
        cols[n] = 7'(v);
        n++;
      end
    end
    return cols;
  endfunction

  localparam secded_cols_t SecdedCols = secded_cols();

endpackage

// File: rtl/prim_secded_39_32_dec.sv
// Hsiao (39,32) SECDED decoder: corrects single-bit errors, flags double-bit errors.
module prim_secded_39_32_dec
  import ecc_scrubber_pkg::*;
(
  input  logic [38:0] data_i,
  output logic [31:0] data_o,
  output logic [1:0]  err_o
);

  logic [6:0] syndrome;

  always_comb begin
    syndrome = data_i[38:32];
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) syndrome = syndrome ^ SecdedCols[i];
    end
  end

  always_comb begin
    data_o = data_i[31:0];
    for (int i = 0; i < 32; i++) begin
      data_o[i] = data_i[i] ^ (syndrome == SecdedCols[i]);
    end
  end

  // Odd-weight syndrome: single error; even non-zero: double error.
  assign err_o = {~(^syndrome) & (|syndrome), ^syndrome};

endmodule

// File: rtl/prim_secded_39_32_enc.sv
// Hsiao (39,32) SECDED encoder: codeword = {parity[6:0], data[31:0]}.
module prim_secded_39_32_enc
  import ecc_scrubber_pkg::*;
(
  input  logic [31:0] data_i,
  output logic [38:0] data_o
);

  logic [6:0] parity;

  always_comb begin
    parity = '0;
    for (int i = 0; i < 32; i++) begin
      if (data_i[i]) parity = parity ^ SecdedCols[i];
    end
  end

  assign data_o = {parity, data_i};

endmodule

// File: rtl/ecc_scrubber.sv
// Background ECC scrubber sharing the protected bank port with the interconnect.
// Define ECC_SCRUBBER_COUNTERS_EN to implement the saturating fix/uncorrectable counters.
module ecc_scrubber
  import ecc_scrubber_pkg::*;
#(
  parameter int unsigned BankSize         = 256,
  parameter int unsigned UnprotectedWidth = SecdedDataW,
  parameter int unsigned ProtectedWidth   = SecdedCodeW,
  localparam int unsigned BankAddWidth    = $clog2(BankSize)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [31:0]               scrub_interval_i,
  input  logic                      intc_req_i,
  input  logic                      intc_we_i,
  input  logic [BankAddWidth-1:0]   intc_add_i,
  input  logic [ProtectedWidth-1:0] intc_wdata_i,
  output logic                      intc_gnt_o,
  output logic [ProtectedWidth-1:0] intc_rdata_o,
  output logic                      bank_req_o,
  output logic                      bank_we_o,
  output logic [BankAddWidth-1:0]   bank_add_o,
  output logic [ProtectedWidth-1:0] bank_wdata_o,
  input  logic [ProtectedWidth-1:0] bank_rdata_i,
  output logic                      scrub_fix_o,
  output logic                      scrub_uncorr_o,
  output logic [31:0]               fix_count_o,
  output logic [31:0]               uncorr_count_o
);

  localparam logic [BankAddWidth-1:0] LastAddr = BankAddWidth'(BankSize - 1);

  scrub_state_e                state_q;
  logic [31:0]                 interval_q;
  logic [BankAddWidth-1:0]     scrub_addr_q;
  logic [BankAddWidth-1:0]     scrub_addr_next;
  logic [ProtectedWidth-1:0]   corr_q;
  logic [ProtectedWidth-1:0]   corr_cw;
  logic [UnprotectedWidth-1:0] dec_data;
  logic [1:0]                  dec_err;
  logic                        intc_hit;
  logic                        own_port;
  logic                        scrub_rd;

  prim_secded_39_32_dec u_dec (
    .data_i (bank_rdata_i),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  prim_secded_39_32_enc u_enc (
    .data_i (dec_data),
    .data_o (corr_cw)
  );

  assign scrub_addr_next = (scrub_addr_q == LastAddr) ? '0 : scrub_addr_q + 1'b1;
  assign intc_hit        = intc_req_i && intc_we_i && (intc_add_i == scrub_addr_q);

  // Reset gates the scrubber's port ownership so an aborted scrub never writes.
  assign own_port = (state_q == CORRECT) && !rst_i;
  assign scrub_rd = (state_q == READ) && !intc_req_i && !rst_i;

  assign intc_gnt_o     = !own_port;
  assign intc_rdata_o   = bank_rdata_i;
  assign scrub_fix_o    = own_port;
  assign scrub_uncorr_o = (state_q == CHECK) && dec_err[1] && !rst_i;

  always_comb begin
    bank_req_o   = intc_req_i;
    bank_we_o    = intc_we_i;
    bank_add_o   = intc_add_i;
    bank_wdata_o = intc_wdata_i;
    if (own_port) begin
      bank_req_o   = 1'b1;
      bank_we_o    = 1'b1;
      bank_add_o   = scrub_addr_q;
      bank_wdata_o = corr_q;
    end else if (scrub_rd) begin
      bank_req_o = 1'b1;
      bank_we_o  = 1'b0;
      bank_add_o = scrub_addr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      scrub_addr_q <= '0;
      interval_q   <= scrub_interval_i;
    end else begin
      case (state_q)
        IDLE: begin
          if (scrub_interval_i != '0) begin
            if (interval_q == '0) begin
              interval_q <= scrub_interval_i;
            end else if (interval_q == 32'd1) begin
              state_q <= READ;
            end else begin
              interval_q <= interval_q - 32'd1;
            end
          end
        end
        READ: begin
          if (!intc_req_i) state_q <= CHECK;
        end
        CHECK: begin
          if (dec_err[0] && !intc_hit) begin
            state_q <= CORRECT;
          end else begin
            state_q      <= IDLE;
            scrub_addr_q <= scrub_addr_next;
            interval_q   <= scrub_interval_i;
          end
        end
        CORRECT: begin
          state_q      <= IDLE;
          scrub_addr_q <= scrub_addr_next;
          interval_q   <= scrub_interval_i;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == CHECK) corr_q <= corr_cw;
  end

`ifdef ECC_SCRUBBER_COUNTERS_EN
  logic [31:0] fix_cnt_q;
  logic [31:0] uncorr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fix_cnt_q    <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (scrub_fix_o && (fix_cnt_q != '1)) fix_cnt_q <= fix_cnt_q + 32'd1;
      if (scrub_uncorr_o && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 32'd1;
    end
  end

  assign fix_count_o    = fix_cnt_q;
  assign uncorr_count_o = uncorr_cnt_q;
`else
  assign fix_count_o    = '0;
  assign uncorr_count_o = '0;
`endif

endmodule

// File: tb/tb_ecc_scrubber.sv
// Self-checking bench for ecc_scrubber with a behavioural 16-word bank behind the port.
module tb_ecc_scrubber;

  localparam int unsigned BankSize = 16;
  localparam int AW = 4;
`ifdef ECC_SCRUBBER_COUNTERS_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic          clk_i;
  logic          rst_i;
  logic [31:0]   scrub_interval_i;
  logic          intc_req_i;
  logic          intc_we_i;
  logic [AW-1:0] intc_add_i;
  logic [38:0]   intc_wdata_i;
  logic          intc_gnt_o;
  logic [38:0]   intc_rdata_o;
  logic          bank_req_o;
  logic          bank_we_o;
  logic [AW-1:0] bank_add_o;
  logic [38:0]   bank_wdata_o;
  logic [38:0]   bank_rdata_i;
  logic          scrub_fix_o;
  logic          scrub_uncorr_o;
  logic [31:0]   fix_count_o;
  logic [31:0]   uncorr_count_o;

  ecc_scrubber #(.BankSize(BankSize)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .scrub_interval_i (scrub_interval_i),
    .intc_req_i       (intc_req_i),
    .intc_we_i        (intc_we_i),
    .intc_add_i       (intc_add_i),
    .intc_wdata_i     (intc_wdata_i),
    .intc_gnt_o       (intc_gnt_o),
    .intc_rdata_o     (intc_rdata_o),
    .bank_req_o       (bank_req_o),
    .bank_we_o        (bank_we_o),
    .bank_add_o       (bank_add_o),
    .bank_wdata_o     (bank_wdata_o),
    .bank_rdata_i     (bank_rdata_i),
    .scrub_fix_o      (scrub_fix_o),
    .scrub_uncorr_o   (scrub_uncorr_o),
    .fix_count_o      (fix_count_o),
    .uncorr_count_o   (uncorr_count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Bank model: one-cycle read latency, write on request.
  logic [38:0] mem [BankSize];
  initial begin
    bank_rdata_i = '0;
    forever begin
      @(posedge clk_i);
      if (bank_req_o === 1'b1) begin
        if (bank_we_o === 1'b1) mem[bank_add_o] <= bank_wdata_o;
        else bank_rdata_i <= mem[bank_add_o];
      end
    end
  end

  // Observed scrubber activity.
  int cyc, rd_n, wr_n, fix_n, unc_n, gnt_low_n;
  int rd_addr[$];
  int rd_cyc[$];
  initial begin
    cyc = 0; rd_n = 0; wr_n = 0; fix_n = 0; unc_n = 0; gnt_low_n = 0;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (bank_req_o === 1'b1 && bank_we_o === 1'b0 && intc_req_i === 1'b0) begin
        rd_addr.push_back(int'(bank_add_o));
        rd_cyc.push_back(cyc);
        rd_n++;
      end
      if (intc_gnt_o === 1'b0) begin
        gnt_low_n++;
        if (bank_req_o === 1'b1 && bank_we_o === 1'b1) wr_n++;
      end
      if (scrub_fix_o === 1'b1) fix_n++;
      if (scrub_uncorr_o === 1'b1) unc_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int exp_fix_cnt = 0;
  int exp_unc_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Reference code: data bit i maps to the i-th 7-bit value with exactly three ones.
  int ref_cols[32];
  function automatic logic [38:0] ref_encode(input logic [31:0] d);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (d[i]) p = p ^ 7'(ref_cols[i]);
    return {p, d};
  endfunction

  task automatic check_counters(input string nm);
    check({nm, "_fix_count"}, fix_count_o, CntEn ? exp_fix_cnt : 0);
    check({nm, "_uncorr_count"}, uncorr_count_o, CntEn ? exp_unc_cnt : 0);
  endtask

  task automatic wait_read(output bit ok);
    int start;
    start = rd_n;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i); #1;
      if (rd_n > start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("scrub_read_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_word(input int addr, input bit efix, input bit eunc,
                            input logic [38:0] eraw, input logic [38:0] eword, input int egap);
    int f0, u0, g0, w0;
    bit ok;
    f0 = fix_n; u0 = unc_n; g0 = gnt_low_n; w0 = wr_n;
    wait_read(ok);
    if (!ok) return;
    check("scrub_rd_addr", rd_addr[rd_n-1], addr);
    if (egap > 0) check("scrub_rd_gap", rd_cyc[rd_n-1] - rd_cyc[rd_n-2], egap);
    @(negedge clk_i); #1;
    check("check_rdata", intc_rdata_o, eraw);
    check("uncorr_in_check", scrub_uncorr_o, eunc);
    repeat (2) begin @(negedge clk_i); #1; end
    exp_fix_cnt += int'(efix);
    exp_unc_cnt += int'(eunc);
    check("fix_pulses", fix_n - f0, efix);
    check("uncorr_pulses", unc_n - u0, eunc);
    check("gnt_low_cycles", gnt_low_n - g0, efix);
    check("scrub_writes", wr_n - w0, efix);
    check("mem_word", mem[addr], eword);
    check_counters("word");
  endtask

  typedef struct {
    int          addr;
    logic [38:0] mask;
    bit          exp_fix;
    bit          exp_unc;
    logic [38:0] exp_word;
  } vec_t;

  vec_t        vt[9];
  logic [38:0] clean [BankSize];
  logic [38:0] stored [BankSize];

  initial begin
    logic [38:0] one;
    logic [38:0] w9_new;
    logic [38:0] w1_bad;
    int n, w, k1, k2, mis, r0, w0, f0, prev_add;
    bit ok;

    one = 39'd1;
    n = 0;
    for (int v = 0; v < 128; v++) begin
      w = 0;
      for (int b = 0; b < 7; b++) if (((v >> b) & 1) == 1) w++;
      if (w == 3 && n < 32) begin
        ref_cols[n] = v;
        n++;
      end
    end

    for (int i = 0; i < int'(BankSize); i++) begin
      clean[i]  = ref_encode($urandom);
      stored[i] = clean[i];
    end

    k1 = $urandom_range(38, 0);
    k2 = (k1 + $urandom_range(38, 1)) % 39;
    for (int i = 0; i < 9; i++) begin
      vt[i].addr = i;
      vt[i].mask = '0;
    end
    vt[4].mask = one << $urandom_range(38, 0);
    vt[5].mask = one << 3;
    vt[7].mask = (one << 3) | (one << 17);
    vt[8].mask = (one << k1) | (one << k2);
    for (int i = 0; i < 9; i++) begin
      vt[i].exp_fix  = ($countones(vt[i].mask) == 1);
      vt[i].exp_unc  = ($countones(vt[i].mask) == 2);
      stored[i]      = clean[i] ^ vt[i].mask;
      vt[i].exp_word = vt[i].exp_fix ? clean[i] : stored[i];
    end
    stored[9] = clean[9] ^ (one << $urandom_range(38, 0));
    w9_new    = ref_encode(32'h0000_00A5);

    rst_i = 1'b1;
    scrub_interval_i = '0;
    intc_req_i = 1'b0;
    intc_we_i = 1'b0;
    intc_add_i = '0;
    intc_wdata_i = '0;

    // Preload through the port while reset holds the scrubber off it.
    mis = 0;
    for (int i = 0; i < int'(BankSize); i++) begin
      @(posedge clk_i); #1;
      intc_req_i = 1'b1; intc_we_i = 1'b1; intc_add_i = AW'(i); intc_wdata_i = stored[i];
      @(negedge clk_i); #1;
      if (bank_req_o !== 1'b1 || bank_we_o !== 1'b1 || bank_add_o !== AW'(i) ||
          bank_wdata_o !== stored[i] || intc_gnt_o !== 1'b1 ||
          scrub_fix_o !== 1'b0 || scrub_uncorr_o !== 1'b0) mis++;
    end
    check("reset_mirror", mis, 0);
    @(posedge clk_i); #1;
    intc_req_i = 1'b0; intc_we_i = 1'b0;
    @(negedge clk_i); #1;
    check("reset_gnt", intc_gnt_o, 1);
    check("reset_fix", scrub_fix_o, 0);
    check("reset_uncorr", scrub_uncorr_o, 0);
    check("reset_bank_req", bank_req_o, 0);
    check_counters("reset");
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    repeat (30) begin @(negedge clk_i); #1; end
    check("interval0_no_read", rd_n, 0);
    @(posedge clk_i); #1;
    scrub_interval_i = 32'd4;

    for (int i = 0; i < 9; i++) begin
      check_word(vt[i].addr, vt[i].exp_fix, vt[i].exp_unc, stored[i], vt[i].exp_word,
                 (i == 0) ? 0 : 6 + int'(vt[i-1].exp_fix));
    end

    // Word 9: single error, superseded by an interconnect write during CHECK.
    f0 = fix_n; w0 = wr_n; r0 = gnt_low_n;
    wait_read(ok);
    check("w9_rd_addr", rd_addr[rd_n-1], 9);
    @(posedge clk_i); #1;
    intc_req_i = 1'b1; intc_we_i = 1'b1; intc_add_i = AW'(9); intc_wdata_i = w9_new;
    @(negedge clk_i); #1;
    check("w9_gnt_in_check", intc_gnt_o, 1);
    @(posedge clk_i); #1;
    intc_req_i = 1'b0; intc_we_i = 1'b0;
    repeat (3) begin @(negedge clk_i); #1; end
    check("w9_mem", mem[9], w9_new);
    check("w9_fix_pulses", fix_n - f0, 0);
    check("w9_scrub_writes", wr_n - w0, 0);
    check("w9_gnt_low", gnt_low_n - r0, 0);

    // Interconnect holds the port for 100 cycles; scrubber parks in READ.
    mis = 0; r0 = rd_n; w0 = wr_n; prev_add = -1;
    @(posedge clk_i); #1;
    for (int i = 0; i < 100; i++) begin
      intc_req_i = 1'b1; intc_we_i = 1'b0; intc_add_i = AW'($urandom);
      @(negedge clk_i); #1;
      if (bank_req_o !== 1'b1 || bank_we_o !== 1'b0 || bank_add_o !== intc_add_i ||
          intc_gnt_o !== 1'b1) mis++;
      if (prev_add >= 0 && intc_rdata_o !== mem[prev_add]) mis++;
      prev_add = int'(intc_add_i);
      @(posedge clk_i); #1;
    end
    intc_req_i = 1'b0;
    check("hold_mirror", mis, 0);
    check("hold_no_scrub_read", rd_n - r0, 0);
    check("hold_no_scrub_write", wr_n - w0, 0);
    @(negedge clk_i); #1;
    check("resume_read_count", rd_n - r0, 1);
    check("resume_read_addr", rd_addr[rd_n-1], 10);
    repeat (3) begin @(negedge clk_i); #1; end

    for (int a = 11; a <= int'(BankSize); a++) begin
      check_word(a % int'(BankSize), 1'b0, 1'b0, clean[a % int'(BankSize)],
                 clean[a % int'(BankSize)], 6);
    end

    // Reset during CHECK of a correctable word: no write-back, restart at 0.
    w1_bad = clean[1] ^ (one << $urandom_range(38, 0));
    @(posedge clk_i); #1;
    intc_req_i = 1'b1; intc_we_i = 1'b1; intc_add_i = AW'(1); intc_wdata_i = w1_bad;
    @(posedge clk_i); #1;
    intc_req_i = 1'b0; intc_we_i = 1'b0;
    wait_read(ok);
    check("rst_rd_addr", rd_addr[rd_n-1], 1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    w0 = wr_n; f0 = fix_n;
    @(negedge clk_i); #1;
    check("rst_gnt", intc_gnt_o, 1);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    exp_fix_cnt = 0;
    exp_unc_cnt = 0;
    repeat (3) begin @(negedge clk_i); #1; end
    check("rst_no_write", wr_n - w0, 0);
    check("rst_no_fix", fix_n - f0, 0);
    check("rst_mem_kept", mem[1], w1_bad);
    check_counters("rst");
    wait_read(ok);
    check("rst_restart_addr", rd_addr[rd_n-1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
